// File: rtl/binned_mask_centroid.sv
// Per-frame centroid, area and bounding box of a binned 1-bit mask stream.
// Totals are snapshotted at frame end and divided by a pair of sequential restoring dividers.
module binned_mask_centroid #(
  parameter int unsigned HRES = 320,
  parameter int unsigned VRES = 180,
  localparam int unsigned HWIDTH = $clog2(HRES),
  localparam int unsigned VWIDTH = $clog2(VRES),
  localparam int unsigned AREA_W = $clog2(HRES*VRES+1),
  localparam int unsigned DIV_W  = $clog2(HRES*VRES*HRES)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [HWIDTH-1:0] hcount_in,
  input  logic [VWIDTH-1:0] vcount_in,
  input  logic              pixel_data_in,
  input  logic              data_valid_in,
  output logic [HWIDTH-1:0] x_out,
  output logic [VWIDTH-1:0] y_out,
  output logic [AREA_W-1:0] area_out,
  output logic [HWIDTH-1:0] min_x_out,
  output logic [HWIDTH-1:0] max_x_out,
  output logic [VWIDTH-1:0] min_y_out,
  output logic [VWIDTH-1:0] max_y_out,
  output logic              found_out,
  output logic              valid_out,
  output logic              overrun_out
);

  localparam int unsigned REM_W = DIV_W - 1;
  localparam int unsigned CNT_W = $clog2(DIV_W);

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  state_t state_q, state_d;

  logic [AREA_W-1:0] area_q, area_d, area_n, snap_area_q, snap_area_d;
  logic [DIV_W-1:0]  sum_x_q, sum_x_d, sum_x_n, sum_y_q, sum_y_d, sum_y_n;
  logic [HWIDTH-1:0] min_x_q, min_x_d, min_x_n, max_x_q, max_x_d, max_x_n;
  logic [VWIDTH-1:0] min_y_q, min_y_d, min_y_n, max_y_q, max_y_d, max_y_n;
  logic [HWIDTH-1:0] snap_min_x_q, snap_min_x_d, snap_max_x_q, snap_max_x_d;
  logic [VWIDTH-1:0] snap_min_y_q, snap_min_y_d, snap_max_y_q, snap_max_y_d;

  logic [DIV_W-1:0]  xq_q, xq_d, yq_q, yq_d, divisor, xr_sh, yr_sh;
  logic [REM_W-1:0]  xr_q, xr_d, yr_q, yr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [HWIDTH-1:0] x_q, x_d, omin_x_q, omin_x_d, omax_x_q, omax_x_d;
  logic [VWIDTH-1:0] y_q, y_d, omin_y_q, omin_y_d, omax_y_q, omax_y_d;
  logic [AREA_W-1:0] oarea_q, oarea_d;
  logic              found_q, found_d, valid_q, valid_d, overrun_q, overrun_d;

  logic accept, set_pix, frame_end;

  always_comb begin
    accept    = data_valid_in && (hcount_in < HWIDTH'(HRES)) && (vcount_in < VWIDTH'(VRES));
    set_pix   = accept && pixel_data_in;
    frame_end = accept && (hcount_in == HWIDTH'(HRES-1)) && (vcount_in == VWIDTH'(VRES-1));

    // Running totals including the current beat's pixel
    area_n  = area_q + AREA_W'(set_pix);
    sum_x_n = sum_x_q + (set_pix ? DIV_W'(hcount_in) : '0);
    sum_y_n = sum_y_q + (set_pix ? DIV_W'(vcount_in) : '0);
    min_x_n = (set_pix && hcount_in < min_x_q) ? hcount_in : min_x_q;
    max_x_n = (set_pix && hcount_in > max_x_q) ? hcount_in : max_x_q;
    min_y_n = (set_pix && vcount_in < min_y_q) ? vcount_in : min_y_q;
    max_y_n = (set_pix && vcount_in > max_y_q) ? vcount_in : max_y_q;

    divisor = DIV_W'(snap_area_q);
    xr_sh   = {xr_q, xq_q[DIV_W-1]};
    yr_sh   = {yr_q, yq_q[DIV_W-1]};

    state_d      = state_q;
    snap_area_d  = snap_area_q;
    snap_min_x_d = snap_min_x_q;
    snap_max_x_d = snap_max_x_q;
    snap_min_y_d = snap_min_y_q;
    snap_max_y_d = snap_max_y_q;
    xq_d = xq_q;
    yq_d = yq_q;
    xr_d = xr_q;
    yr_d = yr_q;
    cnt_d = cnt_q;
    x_d = x_q;
    y_d = y_q;
    oarea_d = oarea_q;
    omin_x_d = omin_x_q;
    omax_x_d = omax_x_q;
    omin_y_d = omin_y_q;
    omax_y_d = omax_y_q;
    found_d = found_q;
    valid_d = 1'b0;
    overrun_d = 1'b0;

    area_d  = area_n;
    sum_x_d = sum_x_n;
    sum_y_d = sum_y_n;
    min_x_d = min_x_n;
    max_x_d = max_x_n;
    min_y_d = min_y_n;
    max_y_d = max_y_n;
    if (frame_end) begin
      area_d  = '0;
      sum_x_d = '0;
      sum_y_d = '0;
      min_x_d = HWIDTH'(HRES-1);
      max_x_d = '0;
      min_y_d = VWIDTH'(VRES-1);
      max_y_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (frame_end) begin
          snap_area_d  = area_n;
          snap_min_x_d = min_x_n;
          snap_max_x_d = max_x_n;
          snap_min_y_d = min_y_n;
          snap_max_y_d = max_y_n;
          xq_d  = sum_x_n;
          yq_d  = sum_y_n;
          xr_d  = '0;
          yr_d  = '0;
          cnt_d = '0;
          state_d = (area_n == '0) ? DONE : DIVIDE;
        end
      end
      DIVIDE: begin
        // One restoring step per cycle; quotient bits shift into the dividend register
        if (xr_sh >= divisor) begin
          xr_d = REM_W'(xr_sh - divisor);
          xq_d = {xq_q[DIV_W-2:0], 1'b1};
        end else begin
          xr_d = REM_W'(xr_sh);
          xq_d = {xq_q[DIV_W-2:0], 1'b0};
        end
        if (yr_sh >= divisor) begin
          yr_d = REM_W'(yr_sh - divisor);
          yq_d = {yq_q[DIV_W-2:0], 1'b1};
        end else begin
          yr_d = REM_W'(yr_sh);
          yq_d = {yq_q[DIV_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV_W-1)) state_d = DONE;
        overrun_d = frame_end;
      end
      DONE: begin
        found_d = (snap_area_q != '0);
        oarea_d = snap_area_q;
        if (snap_area_q != '0) begin
          x_d = HWIDTH'(xq_q);
          y_d = VWIDTH'(yq_q);
          omin_x_d = snap_min_x_q;
          omax_x_d = snap_max_x_q;
          omin_y_d = snap_min_y_q;
          omax_y_d = snap_max_y_q;
        end else begin
          x_d = '0;
          y_d = '0;
          omin_x_d = '0;
          omax_x_d = '0;
          omin_y_d = '0;
          omax_y_d = '0;
        end
        valid_d   = 1'b1;
        overrun_d = frame_end;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      area_q <= '0;
      sum_x_q <= '0;
      sum_y_q <= '0;
      min_x_q <= HWIDTH'(HRES-1);
      max_x_q <= '0;
      min_y_q <= VWIDTH'(VRES-1);
      max_y_q <= '0;
      snap_area_q <= '0;
      snap_min_x_q <= '0;
      snap_max_x_q <= '0;
      snap_min_y_q <= '0;
      snap_max_y_q <= '0;
      xq_q <= '0;
      yq_q <= '0;
      xr_q <= '0;
      yr_q <= '0;
      cnt_q <= '0;
      x_q <= '0;
      y_q <= '0;
      oarea_q <= '0;
      omin_x_q <= '0;
      omax_x_q <= '0;
      omin_y_q <= '0;
      omax_y_q <= '0;
      found_q <= 1'b0;
      valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      area_q <= area_d;
      sum_x_q <= sum_x_d;
      sum_y_q <= sum_y_d;
      min_x_q <= min_x_d;
      max_x_q <= max_x_d;
      min_y_q <= min_y_d;
      max_y_q <= max_y_d;
      snap_area_q <= snap_area_d;
      snap_min_x_q <= snap_min_x_d;
      snap_max_x_q <= snap_max_x_d;
      snap_min_y_q <= snap_min_y_d;
      snap_max_y_q <= snap_max_y_d;
      xq_q <= xq_d;
      yq_q <= yq_d;
      xr_q <= xr_d;
      yr_q <= yr_d;
      cnt_q <= cnt_d;
      x_q <= x_d;
      y_q <= y_d;
      oarea_q <= oarea_d;
      omin_x_q <= omin_x_d;
      omax_x_q <= omax_x_d;
      omin_y_q <= omin_y_d;
      omax_y_q <= omax_y_d;
      found_q <= found_d;
      valid_q <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign x_out       = x_q;
  assign y_out       = y_q;
  assign area_out    = oarea_q;
  assign min_x_out   = omin_x_q;
  assign max_x_out   = omax_x_q;
  assign min_y_out   = omin_y_q;
  assign max_y_out   = omax_y_q;
  assign found_out   = found_q;
  assign valid_out   = valid_q;
  assign overrun_out = overrun_q;

endmodule

// File: doc/binned_mask_centroid.md
Name: binned_mask_centroid

Overview:
- Consumes the binned 1-bit mask stream produced by the 4x4 binning stage: one beat per binned pixel, with downsampled hcount/vcount.
- Per frame, accumulates the set-pixel count, the coordinate sums and the bounding box.
- At frame end, snapshots these totals and computes the centroid with a sequential restoring divider.
- Publishes a one-cycle result strobe for the downstream tracker/overlay logic.
- Accumulation of the next frame continues while the divider runs.

Parameters:
- HRES, 320, binned frame width in pixels.
- VRES, 180, binned frame height in pixels.
- HWIDTH, $clog2(HRES), hcount width (derived localparam).
- VWIDTH, $clog2(VRES), vcount width (derived localparam).
- AREA_W, $clog2(HRES*VRES+1), set-pixel count width (derived).
- DIV_W, $clog2(HRES*VRES*HRES), sum and divider width (derived; covers both X and Y sums).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- hcount_in  input  HWIDTH  binned column of current beat
- vcount_in  input  VWIDTH  binned row of current beat
- pixel_data_in  input  1  mask bit (1 = pixel set)
- data_valid_in  input  1  beat qualifier
- x_out  output  HWIDTH  centroid column, floor(sum_x/area)
- y_out  output  VWIDTH  centroid row, floor(sum_y/area)
- area_out  output  AREA_W  set-pixel count of the frame
- min_x_out, max_x_out  output  HWIDTH  bounding box columns
- min_y_out, max_y_out  output  VWIDTH  bounding box rows
- found_out  output  1  frame contained at least one set pixel
- valid_out  output  1  one-cycle strobe; all result outputs are valid and held until the next strobe
- overrun_out  output  1  one-cycle pulse when a frame-end beat arrives while the divider is busy

Behaviour:
- Reset:
  - All outputs are 0.
  - Accumulators are cleared: area 0, sums 0, min_x = HRES-1, min_y = VRES-1, max_x = 0, max_y = 0.
  - FSM goes to IDLE; any division in flight is abandoned with no strobe.
- Accepted beat: data_valid_in=1, hcount_in<HRES and vcount_in<VRES. Out-of-range beats are ignored entirely.
- Accumulate: on an accepted beat with pixel_data_in=1:
  - area += 1; sum_x += hcount_in; sum_y += vcount_in.
  - min/max updated with standard compare.
- Frame end: accepted beat with hcount_in==HRES-1 and vcount_in==VRES-1. The beat's own pixel is included.
  - Same edge: snapshot the totals including that pixel.
  - Same edge: reset accumulators to their cleared values.
  - Same edge: the FSM leaves IDLE.
- FSM states:
  - IDLE: waits for a frame end. On frame end with snapshot area==0, go to DONE; otherwise go to DIVIDE and load the X and Y dividers.
  - DIVIDE: X and Y restoring dividers run in parallel, one quotient bit per cycle, MSB first, for exactly DIV_W cycles, then go to DONE.
  - DONE: on one edge, register all outputs and drive valid_out=1 for one cycle, then return to IDLE.
- Latency: valid_out is high in the cycle after the edge occurring DIV_W+1 edges after the frame-end sampling edge. With area==0 this is 1 edge.
- Zero area: found_out=0; x_out, y_out, area_out and all bbox outputs are 0.
- Nonzero area: found_out=1; quotients are truncated to HWIDTH/VWIDTH. A quotient never exceeds HRES-1/VRES-1.
- Frame end while busy: a frame end in DIVIDE or DONE pulses overrun_out for one cycle.
  - The running division is unaffected.
  - The new frame's totals are discarded and accumulators are still cleared.
- Continuity: beats arriving during DIVIDE/DONE accumulate normally into the next frame.
- data_valid_in gaps of any length are permitted; only beats count, not cycles.

Test Plan:
- Single pixel: set pixel at (10,20) only, HRES=320 VRES=180 -> valid_out after DIV_W+1 edges; x=10, y=20, area=1, bbox 10..10 / 20..20, found=1.
- Square: 3x3 block at cols 100-102, rows 50-52 -> area=9, x=101, y=51, bbox 100..102 / 50..52.
- Truncation: pixels at (0,0) and (3,1) -> area=2, x=1 (floor 1.5), y=0.
- Empty frame: all-zero mask -> valid_out on the edge after the frame-end beat; found=0, all results 0.
- Corner and back-to-back: only the frame-end pixel (319,179) is set, with a second frame streamed immediately -> frame 1 gives x=319, y=179; the second frame accumulates cleanly and gives correct independent results.
- Overrun and robustness: frame end injected during DIVIDE -> overrun_out pulses once and the first result is unchanged. Reset mid-DIVIDE -> no valid_out and all outputs 0. Out-of-range hcount=400 -> ignored.
